// File: rtl/seg7_rx_decoder.sv
// Seven-segment receiver: synchronizes and glitch-filters a segment pattern,
// decodes it to a hex digit and checks digits follow an up-count modulo COUNT_MOD.
module seg7_rx_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_MOD     = 8,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       unknown,
    output logic       blank,
    output logic       seq_err,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [4:0] MOD      = 5'(COUNT_MOD);

    logic [6:0] s1, s2, s2_pol, cand, accepted;
    logic [7:0] cnt;
    logic       have_prev;
    logic [3:0] prev;
    logic       accept;
    logic       dec_known;
    logic [3:0] dec_val;
    logic [4:0] prev_inc, exp_next;
    logic       in_seq;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign s2_pol = (ACTIVE_LOW != 0) ? ~s2 : s2;
    assign accept = (s2_pol == cand) && (cnt == CNT_LAST) && (cand != accepted);
    assign blank  = (accepted == 7'h00);

    always_comb begin
        dec_known = 1'b1;
        dec_val   = 4'h0;
        case (cand)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_known = 1'b0;
        endcase
    end

    // prev can exceed COUNT_MOD-1 after an out-of-range digit, so a true modulo is needed
    assign prev_inc = {1'b0, prev} + 5'd1;
    assign exp_next = prev_inc % MOD;
    assign in_seq   = ({1'b0, dec_val} < MOD) && ({1'b0, dec_val} == exp_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            cand        <= '0;
            cnt         <= '0;
            accepted    <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            unknown     <= 1'b0;
            seq_err     <= 1'b0;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            have_prev   <= 1'b0;
            prev        <= '0;
        end else begin
            s1          <= seg_in;
            s2          <= s1;
            digit_valid <= 1'b0;
            unknown     <= 1'b0;

            if (s2_pol != cand) begin
                cand <= s2_pol;
                cnt  <= '0;
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + 8'd1;
            end

            if (accept) begin
                accepted <= cand;
                if (cand == 7'h00) begin
                    // blank: digit and sequence history are left alone
                end else if (dec_known) begin
                    digit       <= dec_val;
                    digit_valid <= 1'b1;
                    prev        <= dec_val;
                    if (!have_prev) begin
                        have_prev <= 1'b1;
                    end else if (in_seq) begin
                        ok_cnt <= sat_inc(ok_cnt);
                    end else begin
                        seq_err <= 1'b1;
                        err_cnt <= sat_inc(err_cnt);
                    end
                end else begin
                    unknown   <= 1'b1;
                    seq_err   <= 1'b1;
                    err_cnt   <= sat_inc(err_cnt);
                    have_prev <= 1'b0;
                end
            end

            // clear takes priority over a same-edge accept for the status registers
            if (clr) begin
                seq_err <= 1'b0;
                ok_cnt  <= '0;
                err_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Scoreboard bench for seg7_rx_decoder: a segment-level reference model predicts
// each accepted event (cycle, digit, counters) and a monitor checks DUT pulses.
module tb_seg7_rx_decoder;
    localparam int S   = 4;
    localparam int MOD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid, unknown, blank, seq_err;
    logic [7:0] ok_cnt, err_cnt;

    logic       rst_al, clr_al;
    logic [6:0] seg_al;
    logic [3:0] digit_al;
    logic       dv_al, unk_al, blank_al, serr_al;
    logic [7:0] ok_al, err_al;

    seg7_rx_decoder #(.STABLE_CYCLES(S), .COUNT_MOD(MOD), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .clr(clr),
        .digit(digit), .digit_valid(digit_valid), .unknown(unknown), .blank(blank),
        .seq_err(seq_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt));

    seg7_rx_decoder #(.STABLE_CYCLES(1), .COUNT_MOD(16), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst_al), .seg_in(seg_al), .clr(clr_al),
        .digit(digit_al), .digit_valid(dv_al), .unknown(unk_al), .blank(blank_al),
        .seq_err(serr_al), .ok_cnt(ok_al), .err_cnt(err_al));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int al_pulses = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst_al && dv_al) al_pulses++;

    typedef struct {
        int   at;
        bit   is_unk;
        int   digit;
        int   ok;
        int   err;
        bit   serr;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model state, one update per accepted pattern
    logic [6:0] m_acc;
    int m_digit, m_prev, m_ok, m_err;
    bit m_hp, m_serr;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_acc = 7'h00; m_digit = 0; m_prev = 0; m_ok = 0; m_err = 0;
        m_hp = 0; m_serr = 0;
        sbq.delete();
    endtask

    task automatic model_clr();
        m_ok = 0; m_err = 0; m_serr = 0;
    endtask

    task automatic model_accept(input logic [6:0] pat, input int at, input bit clr_same);
        int d;
        exp_t e;
        m_acc = pat;
        d = lookup(pat);
        if (pat != 7'h00) begin
            if (d >= 0) begin
                m_digit = d;
                if (!m_hp) m_hp = 1;
                else if (d < MOD && d == (m_prev + 1) % MOD) m_ok = (m_ok < 255) ? m_ok + 1 : 255;
                else begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_serr = 1;
                end
                m_prev = d;
            end else begin
                m_serr = 1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                m_hp = 0;
            end
        end
        if (clr_same) model_clr();
        if (pat != 7'h00) begin
            e.at = at; e.is_unk = (d < 0); e.digit = m_digit;
            e.ok = m_ok; e.err = m_err; e.serr = m_serr;
            sbq.push_back(e);
        end
    endtask

    // Hold pat for 'hold' edges; clr_k (if nonzero, >=3) pulses clr at that edge of the hold.
    task automatic drive(input logic [6:0] pat, input int hold, input int clr_k);
        int start;
        int ev;
        bit has_ev;
        start  = cyc;
        ev     = S + 3;
        has_ev = (hold >= S + 1) && (pat != m_acc);
        seg_in = pat;
        if (clr_k != 0 && (clr_k < ev || !has_ev)) model_clr();
        if (has_ev) model_accept(pat, start + ev, clr_k == ev);
        if (has_ev && clr_k > ev) model_clr();
        for (int k = 1; k <= hold; k++) begin
            clr = (k == clr_k);
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].at < cyc) begin
                mon_e = sbq.pop_front();
                n_checks++; n_err++;
                $display("FAIL missed_event: expected at cycle %0d, not observed by %0d", mon_e.at, cyc);
            end
            if (digit_valid || unknown) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_event: dv=%0b unk=%0b digit=%0d at cycle %0d, none expected",
                             digit_valid, unknown, digit, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("event_cycle", cyc, mon_e.at);
                    check("unknown", int'(unknown), int'(mon_e.is_unk));
                    check("digit_valid", int'(digit_valid), int'(!mon_e.is_unk));
                    check("digit", int'(digit), mon_e.digit);
                    check("ok_cnt", int'(ok_cnt), mon_e.ok);
                    check("err_cnt", int'(err_cnt), mon_e.err);
                    check("seq_err", int'(seq_err), int'(mon_e.serr));
                    check("blank_on_event", int'(blank), 0);
                end
            end
        end
    end

    initial begin
        logic [6:0] pat;
        int hold, clr_k, r, base;
        rst = 1'b1; clr = 1'b0; seg_in = 7'h00;
        rst_al = 1'b1; clr_al = 1'b0; seg_al = 7'h7F;
        model_reset();
        repeat (3) @(negedge clk);
        rst_al = 1'b0;
        do_reset();
        check("rst_digit", int'(digit), 0);
        check("rst_blank", int'(blank), 1);
        check("rst_ok", int'(ok_cnt), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_seq_err", int'(seq_err), 0);
        check("rst_pulses", int'(digit_valid) + int'(unknown), 0);

        // in-order run, wrap 7->0, then an out-of-sequence digit
        drive(7'h3F, 10, 0); drive(7'h06, 10, 0); drive(7'h5B, 10, 0); drive(7'h4F, 10, 0);
        check("ok_after_0123", int'(ok_cnt), 3);
        check("blank_known", int'(blank), 0);
        drive(7'h66, 10, 0); drive(7'h6D, 10, 0); drive(7'h7D, 10, 0); drive(7'h07, 10, 0);
        drive(7'h3F, 10, 0);
        check("ok_after_wrap", int'(ok_cnt), 8);
        drive(7'h5B, 10, 0);
        check("seq_err_after_skip", int'(seq_err), 1);

        // glitch shorter than the filter window
        drive(7'h06, 10, 0); drive(7'h7F, 3, 0); drive(7'h06, 10, 0);
        check("digit_after_glitch", int'(digit), 1);

        // unknown, blank, restart of sequence history
        drive(7'h55, 10, 0);
        drive(7'h00, 10, 0);
        check("blank_level", int'(blank), 1);
        check("digit_held_blank", int'(digit), m_digit);
        drive(7'h06, 10, 0);
        check("err_after_restart", int'(err_cnt), m_err);

        // reset mid-filter, then clr colliding with an out-of-sequence accept
        seg_in = 7'h4F;
        repeat (2) @(negedge clk);
        do_reset();
        drive(7'h4F, 10, 0);
        drive(7'h7D, 10, S + 3);
        check("clr_win_err", int'(err_cnt), 0);
        check("clr_win_digit", int'(digit), 6);

        // randomized segments
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      pat = tbl[(m_prev + 1) % MOD];
            else if (r < 7) pat = tbl[$urandom_range(0, 15)];
            else if (r < 9) pat = 7'($urandom_range(0, 127));
            else            pat = 7'h00;
            while (pat == seg_in) pat = tbl[$urandom_range(0, 15)];
            hold  = $urandom_range(1, S + 6);
            clr_k = ($urandom_range(0, 7) == 0 && hold >= 3) ? $urandom_range(3, hold) : 0;
            drive(pat, hold, clr_k);
            if (hold >= S + 3) begin
                check("rand_blank", int'(blank), int'(m_acc == 7'h00));
                check("rand_digit", int'(digit), m_digit);
            end
        end
        drive(seg_in == 7'h3F ? 7'h06 : 7'h3F, S + 6, 0);
        for (int w = 0; w < 100 && sbq.size() > 0; w++) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);

        // active-low source, one-cycle filter, counter saturation
        base = al_pulses;
        seg_al = ~7'h6D;
        repeat (3) @(negedge clk);
        check("al_early", int'(dv_al), 0);
        @(negedge clk);
        check("al_valid", int'(dv_al), 1);
        check("al_digit", int'(digit_al), 5);
        repeat (3) @(negedge clk);
        clr_al = 1'b1; @(negedge clk); clr_al = 1'b0;
        for (int i = 0; i < 260; i++) begin
            seg_al = ~tbl[(6 + i) % 16];
            repeat (2) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("al_ok_sat", int'(ok_al), 255);
        check("al_err", int'(err_al), 0);
        check("al_seq_err", int'(serr_al), 0);
        check("al_pulses", al_pulses - base, 261);
        check("al_last_digit", int'(digit_al), (6 + 259) % 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
